// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the parametrised UART blocks: parity modes,
// receiver FSM states and small bit-level helper functions.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BRK    = 3'd5
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Data is zero-extended to 9 bits, which leaves its XOR unchanged.
  function automatic logic parity_error(input logic [8:0] data, input logic pbit,
                                        input logic [1:0] mode);
    logic x;
    x = (^data) ^ pbit;
    case (mode)
      PAR_ODD:  return ~x;
      PAR_EVEN: return x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// Bit-period tick counter with restart, strobes around the bit mid point
// and an end-of-bit strobe. Shared by the UART receiver and transmitter.
module uart_bit_timer #(
  parameter int CLK_PER_BIT = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic mid_early,
  output logic mid,
  output logic mid_late,
  output logic bit_end
);

  localparam int CW  = $clog2(CLK_PER_BIT);
  localparam int MID = CLK_PER_BIT / 2;

  logic [CW-1:0] cnt_r;

  // Tick counter wrapping at CLK_PER_BIT-1; restart forces tick 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (restart) begin
      cnt_r <= '0;
    end else if (cnt_r == CW'(CLK_PER_BIT - 1)) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign mid_early = (cnt_r == CW'(MID - 1));
  assign mid       = (cnt_r == CW'(MID));
  assign mid_late  = (cnt_r == CW'(MID + 1));
  assign bit_end   = (cnt_r == CW'(CLK_PER_BIT - 1));

endmodule

// File: rtl/uart_rx_param.sv
`timescale 1ns/1ps
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// optional parity, 1 or 2 stop bits, framing/break detection.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 27,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 RXD,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 RXD_READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 BREAK_DET
);

  localparam logic [1:0] PAR_MODE  = 2'(PARITY);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  rx_state_e            state_r, state_next_s;
  logic                 sync_r, rxs_r;
  logic                 samp_early_r, samp_mid_r;
  logic [DATA_BITS-1:0] shreg_r;
  logic [3:0]           bit_idx_r;
  logic                 stop_idx_r;
  logic                 par_err_r;
  logic                 restart_s, complete_s, frame_err_s, maj_s;
  logic                 mid_early_s, mid_s, mid_late_s, bit_end_s;

  uart_bit_timer #(.CLK_PER_BIT(CLK_PER_BIT)) u_timer (
    .clk       (CLK),
    .rst       (RST),
    .restart   (restart_s),
    .mid_early (mid_early_s),
    .mid       (mid_s),
    .mid_late  (mid_late_s),
    .bit_end   (bit_end_s)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state; every bit decision happens at tick M+1 using the current rxs as third sample.
  always_comb begin
    state_next_s = state_r;
    restart_s    = 1'b0;
    complete_s   = 1'b0;
    frame_err_s  = 1'b0;
    maj_s        = majority3(samp_early_r, samp_mid_r, rxs_r);
    case (state_r)
      S_IDLE: begin
        if (!rxs_r) begin
          state_next_s = S_START;
        end else begin
          restart_s = 1'b1;
        end
      end
      S_START: begin
        if (mid_late_s && maj_s) begin
          state_next_s = S_IDLE;
          restart_s    = 1'b1;
        end else if (bit_end_s) begin
          state_next_s = S_DATA;
        end else begin
          state_next_s = S_START;
        end
      end
      S_DATA: begin
        if (bit_end_s && (bit_idx_r == LAST_BIT)) begin
          state_next_s = (PAR_MODE != PAR_NONE) ? S_PARITY : S_STOP;
        end else begin
          state_next_s = S_DATA;
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          state_next_s = S_STOP;
        end else begin
          state_next_s = S_PARITY;
        end
      end
      S_STOP: begin
        if (mid_late_s && !maj_s) begin
          complete_s  = 1'b1;
          frame_err_s = 1'b1;
        end else if (mid_late_s && (stop_idx_r == LAST_STOP)) begin
          complete_s = 1'b1;
        end else begin
          complete_s = 1'b0;
        end
        // Re-arm without waiting for the rest of the stop bit.
        if (complete_s) begin
          restart_s    = 1'b1;
          state_next_s = (frame_err_s && !rxs_r) ? S_BRK : S_IDLE;
        end else begin
          state_next_s = S_STOP;
        end
      end
      S_BRK: begin
        restart_s = 1'b1;
        if (rxs_r) begin
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_BRK;
        end
      end
      default: begin
        state_next_s = S_IDLE;
        restart_s    = 1'b1;
      end
    endcase
  end

  // Synchroniser, vote samples, shift register, counters and registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_r       <= 1'b1;
      rxs_r        <= 1'b1;
      samp_early_r <= 1'b1;
      samp_mid_r   <= 1'b1;
      shreg_r      <= '0;
      bit_idx_r    <= 4'd0;
      stop_idx_r   <= 1'b0;
      par_err_r    <= 1'b0;
      DATA         <= '0;
      RXD_READY    <= 1'b0;
      PARITY_ERR   <= 1'b0;
      FRAME_ERR    <= 1'b0;
      BREAK_DET    <= 1'b0;
    end else begin
      sync_r <= RXD;
      rxs_r  <= sync_r;
      if (mid_early_s) samp_early_r <= rxs_r;
      if (mid_s) samp_mid_r <= rxs_r;
      if ((state_r == S_DATA) && mid_late_s) shreg_r <= {maj_s, shreg_r[DATA_BITS-1:1]};
      if (state_r != S_DATA) begin
        bit_idx_r <= 4'd0;
      end else if (bit_end_s) begin
        bit_idx_r <= bit_idx_r + 4'd1;
      end
      if (state_r != S_STOP) begin
        stop_idx_r <= 1'b0;
      end else if (bit_end_s) begin
        stop_idx_r <= 1'b1;
      end
      if ((state_r == S_PARITY) && mid_late_s) begin
        par_err_r <= parity_error(9'(shreg_r), maj_s, PAR_MODE);
      end
      RXD_READY <= complete_s;
      if (complete_s) begin
        DATA       <= shreg_r;
        PARITY_ERR <= par_err_r;
        FRAME_ERR  <= frame_err_s;
      end
      BREAK_DET <= (state_next_s == S_BRK);
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_param: an 8N1 instance and a 7-bit even-parity
// two-stop-bit instance, driven with directed and randomised serial frames.
module tb_uart_rx_param;

  localparam real PERIOD = 37.04;
  localparam real BIT_NS = 1000.0;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rxd0 = 1'b1;
  logic rxd1 = 1'b1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic rdy0, pe0, fe0, bd0, rdy1, pe1, fe1, bd1;

  typedef struct { logic [8:0] d; logic pe; logic fe; } exp_t;
  exp_t    q0[$];
  exp_t    q1[$];
  exp_t    e0, e1;
  realtime rt0[$];
  realtime t_fall0;
  int total = 0;
  int bad = 0;
  int pulses0 = 0;
  int pulses1 = 0;

  always #(PERIOD / 2.0) clk = ~clk;

  uart_rx_param u0 (
    .CLK(clk), .RST(rst), .RXD(rxd0), .DATA(data0), .RXD_READY(rdy0),
    .PARITY_ERR(pe0), .FRAME_ERR(fe0), .BREAK_DET(bd0)
  );

  uart_rx_param #(.CLK_PER_BIT(27), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u1 (
    .CLK(clk), .RST(rst), .RXD(rxd1), .DATA(data1), .RXD_READY(rdy1),
    .PARITY_ERR(pe1), .FRAME_ERR(fe1), .BREAK_DET(bd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive(input int which, input logic b);
    if (which == 0) rxd0 = b;
    else rxd1 = b;
  endtask

  // Expected result comes from the frame content: even parity means the data
  // ones plus the parity bit must be even; any checked stop bit low is a framing error.
  task automatic send_frame(input int which, input logic [8:0] d, input logic pbit,
                            input logic [1:0] stops, input real bit_ns, input bit end_high);
    exp_t e;
    int nb;
    int ns;
    nb  = (which == 0) ? 8 : 7;
    ns  = (which == 0) ? 1 : 2;
    e.d = (which == 0) ? {1'b0, d[7:0]} : {2'b00, d[6:0]};
    e.pe = (which == 0) ? 1'b0 : ((($countones(d[6:0]) + int'(pbit)) % 2) != 0);
    e.fe = (stops[0] == 1'b0) || ((ns == 2) && (stops[1] == 1'b0));
    if (which == 0) begin
      q0.push_back(e);
      t_fall0 = $realtime;
    end else begin
      q1.push_back(e);
    end
    drive(which, 1'b0);
    #(bit_ns);
    for (int i = 0; i < nb; i++) begin
      drive(which, d[i]);
      #(bit_ns);
    end
    if (which == 1) begin
      drive(which, pbit);
      #(bit_ns);
    end
    for (int i = 0; i < ns; i++) begin
      drive(which, stops[i]);
      #(bit_ns);
    end
    if (end_high) drive(which, 1'b1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  // Monitor for the 8N1 instance.
  always @(negedge clk) begin
    if (rdy0) begin
      pulses0++;
      rt0.push_back($realtime);
      if (q0.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u0_unexpected_ready: got data 0x%0h, expected no pulse", data0);
      end else begin
        e0 = q0.pop_front();
        chk("u0_data", 32'(data0), 32'(e0.d));
        chk("u0_perr", 32'(pe0), 32'(e0.pe));
        chk("u0_ferr", 32'(fe0), 32'(e0.fe));
      end
    end
  end

  // Monitor for the 7E2 instance.
  always @(negedge clk) begin
    if (rdy1) begin
      pulses1++;
      if (q1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL u1_unexpected_ready: got data 0x%0h, expected no pulse", data1);
      end else begin
        e1 = q1.pop_front();
        chk("u1_data", 32'(data1), 32'(e1.d));
        chk("u1_perr", 32'(pe1), 32'(e1.pe));
        chk("u1_ferr", 32'(fe1), 32'(e1.fe));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    int skew;
    real bns;
    real dt;
    logic [8:0] d;
    logic [1:0] st;
    logic pb;

    repeat (4) @(negedge clk);
    chk("rst_data0", 32'(data0), 32'd0);
    chk("rst_ready0", 32'(rdy0), 32'd0);
    chk("rst_flags0", 32'({pe0, fe0, bd0}), 32'd0);
    chk("rst_data1", 32'(data1), 32'd0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single 8N1 frame and latency from the RXD falling edge.
    p = pulses0;
    #2;
    send_frame(0, 9'h055, 1'b0, 2'b11, BIT_NS, 1'b1);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("x55_pulses", 32'(pulses0 - p), 32'd1);
    if (rt0.size() > 0) begin
      dt = (rt0[rt0.size() - 1] - t_fall0) / PERIOD;
      chk_range("latency_8n1", $rtoi(dt + 0.5), 259, 261);
    end else begin
      chk("latency_no_pulse", 32'(rt0.size()), 32'd1);
    end

    // Back-to-back frames.
    p = pulses0;
    @(negedge clk);
    #2;
    send_frame(0, 9'h0AA, 1'b0, 2'b11, BIT_NS, 1'b1);
    send_frame(0, 9'h00F, 1'b0, 2'b11, BIT_NS, 1'b1);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("b2b_pulses", 32'(pulses0 - p), 32'd2);
    if (rt0.size() >= 2) begin
      dt = (rt0[rt0.size() - 1] - rt0[rt0.size() - 2]) / PERIOD;
      chk_range("b2b_spacing", $rtoi(dt + 0.5), 268, 272);
    end else begin
      chk("b2b_no_pulses", 32'(rt0.size()), 32'd2);
    end

    // False start: 300 ns glitch.
    p = pulses0;
    @(negedge clk);
    #2;
    rxd0 = 1'b0;
    #300;
    rxd0 = 1'b1;
    #(2.0 * BIT_NS);
    chk("false_start_pulses", 32'(pulses0 - p), 32'd0);
    chk("false_start_data", 32'(data0), 32'h0F);

    // Framing error followed by a long break, then a clean frame.
    send_frame(0, 9'h000, 1'b0, 2'b00, BIT_NS, 1'b0);
    #(10.0 * BIT_NS);
    chk("break_det_high", 32'(bd0), 32'd1);
    chk("break_ferr", 32'(fe0), 32'd1);
    #(10.0 * BIT_NS);
    rxd0 = 1'b1;
    repeat (6) @(negedge clk);
    chk("break_det_low", 32'(bd0), 32'd0);
    send_frame(0, 9'h033, 1'b0, 2'b11, BIT_NS, 1'b1);
    wait_drain();
    chk("after_break_ferr", 32'(fe0), 32'd0);

    // Even parity, 7 data bits: wrong then correct parity bit.
    send_frame(1, 9'h041, 1'b1, 2'b11, BIT_NS, 1'b1);
    wait_drain();
    chk("par_wrong", 32'(pe1), 32'd1);
    send_frame(1, 9'h041, 1'b0, 2'b11, BIT_NS, 1'b1);
    wait_drain();
    chk("par_right", 32'(pe1), 32'd0);
    chk("par_data", 32'(data1), 32'h41);

    // Reset during data bit 4 of 0xC3.
    p = pulses0;
    @(negedge clk);
    #2;
    d = 9'h0C3;
    rxd0 = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rxd0 = d[i];
      #(BIT_NS);
    end
    rxd0 = d[4];
    #(BIT_NS / 2.0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_data", 32'(data0), 32'd0);
    chk("midrst_outs", 32'({rdy0, pe0, fe0, bd0}), 32'd0);
    rxd0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #(2.0 * BIT_NS);
    chk("midrst_pulses", 32'(pulses0 - p), 32'd0);
    send_frame(0, 9'h0C3, 1'b0, 2'b11, BIT_NS * 1.03, 1'b1);
    #(BIT_NS);
    send_frame(0, 9'h0C3, 1'b0, 2'b11, BIT_NS * 0.97, 1'b1);
    wait_drain();

    // Randomised frames on the 8N1 instance.
    for (int k = 0; k < 12; k++) begin
      d    = 9'($urandom);
      skew = int'($urandom_range(0, 60)) - 30;
      bns  = BIT_NS * (1.0 + skew / 1000.0);
      st   = ($urandom_range(0, 5) == 0) ? 2'b10 : 2'b11;
      send_frame(0, d, 1'b0, st, bns, 1'b1);
      if (st != 2'b11) #(1.5 * bns);
      else #(real'($urandom_range(0, 1)) * bns / 2.0);
    end
    wait_drain();

    // Randomised frames on the 7E2 instance.
    for (int k = 0; k < 12; k++) begin
      d    = 9'($urandom);
      pb   = 1'($urandom);
      skew = int'($urandom_range(0, 60)) - 30;
      bns  = BIT_NS * (1.0 + skew / 1000.0);
      st   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(1, d, pb, st, bns, 1'b1);
      if (st != 2'b11) #(1.5 * bns);
      else #(real'($urandom_range(0, 1)) * bns / 2.0);
    end
    wait_drain();
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver. It is the next generation of the fixed 8N1 uart_receive block and sits between the board RXD pin and the command/config logic of the camera design.
- Adds configurable data width, parity and stop bits.
- Adds an input synchroniser and 3-sample majority voting.
- Adds false-start rejection, parity/framing error flags and break handling.
- Delivers one received word per frame with a single-cycle valid strobe.

Parameters:
CLK_PER_BIT, 27, CLK cycles per bit (27 MHz / 1 Mbaud); legal range >= 8
DATA_BITS, 8, data bits per frame; legal 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked; legal 1 or 2

Ports:
CLK  in  1  system clock; single clock domain
RST  in  1  reset; synchronous, active-high
RXD  in  1  asynchronous serial input; idles high
DATA  out  DATA_BITS  last received word, LSB first on the line
RXD_READY  out  1  one-cycle pulse: new DATA and flags valid
PARITY_ERR  out  1  parity mismatch on last frame; 0 when PARITY = 0
FRAME_ERR  out  1  a stop bit sampled low on last frame
BREAK_DET  out  1  high while the line is held low after a framing error

Behaviour:
- Reset: while RST is high at a CLK edge, all outputs go to 0, the FSM goes to IDLE, and the synchroniser flops load 1. RST mid-frame aborts the frame without any RXD_READY.
- Input: 2-flop synchroniser. All decisions use the synchronised signal rxs.
- Counters: bit-timer tick counter 0..CLK_PER_BIT-1; bit index counter.
- Sampling: the mid point is M = CLK_PER_BIT/2 (integer division). The bit value is the majority of rxs at ticks M-1, M and M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK.
- IDLE: on rxs 1->0, clear the tick counter and go to START.
- START: at tick M+1, majority 1 is a false start -> IDLE with no pulse; majority 0 -> DATA.
- DATA: DATA_BITS bits, one per CLK_PER_BIT, shifted into an internal register LSB first. Then go to PARITY if PARITY != 0, else STOP.
- PARITY: compute the parity error. Odd mode: error when XOR(data, pbit) = 0. Even mode: error when XOR(data, pbit) = 1.
- STOP: sample STOP_BITS stop bits. Any stop bit with majority 0 sets the frame error and ends checking.
- Completion: at the clock after the last stop-bit decision (tick M+2):
  - the shift register is copied to DATA;
  - PARITY_ERR and FRAME_ERR are updated;
  - RXD_READY pulses high for exactly 1 cycle.
- Re-arm: the FSM re-arms immediately to IDLE without waiting for the full stop bit, so back-to-back frames and small baud mismatch are tolerated.
- Output hold: DATA and the flags hold until the next completed frame.
- Break: if FRAME_ERR and rxs is still 0 at completion -> BRK with BREAK_DET = 1. BRK exits to IDLE on rxs = 1 and clears BREAK_DET. No start is detected while in BRK.
- Latency (8N1, CLK_PER_BIT = 27, M = 13): RXD_READY rises 2 + 9*27 + 13 + 2 = 260 cycles after the RXD falling edge.
- Glitch rejection: a glitch low shorter than 2 samples around the START mid point is a false start.
- Simultaneous events: a start edge in the cycle of the RXD_READY pulse is not lost. IDLE is entered on that edge, and the next frame's edge is detected from IDLE on the following cycle.

Decomposition:
- Package uart_pkg: parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN, the FSM state enum, and the function majority3.
- One sub-module, uart_bit_timer: tick counter, with restart, mid-sample strobes and end-of-bit strobe. It is reused by the future uart_tx_param.

Test Plan:
- 8N1 frame: start, then 1,0,1,0,1,0,1,0 LSB first, then stop, at 1000 ns/bit with a 37.04 ns CLK -> DATA = 0x55, RXD_READY pulses once, PARITY_ERR = 0, FRAME_ERR = 0.
- Two back-to-back frames, 0xAA followed immediately by 0x0F with a single stop bit -> two RXD_READY pulses 270 +/- 2 cycles apart, values correct.
- False start: 300 ns low pulse (8 cycles, ending before tick M-1) -> FSM back to IDLE, no RXD_READY, DATA unchanged.
- PARITY = 2, DATA_BITS = 7: send 0x41 with a wrong parity bit of 1 -> DATA = 0x41, PARITY_ERR = 1. Then send 0x41 with parity 0 -> PARITY_ERR = 0.
- Framing and break: stop bit low, then line held low for 20 bit times -> FRAME_ERR = 1, BREAK_DET = 1 until RXD returns high, then a normal 0x33 frame is received cleanly.
- Reset mid-frame: assert RST during data bit 4 -> all outputs 0, no RXD_READY; the next full frame 0xC3 is received correctly. Also run with bit-timing skew of +/-3 %, which must still decode correctly.
